// File: rtl/ecualizador_mezcla_pkg.sv
// Shared definitions for the band gain-and-sum stage: FSM encodings,
// gain select codes and the unity-gain helper.
package ecualizador_mezcla_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_B = 3'd1,
    MUL_M = 3'd2,
    MUL_A = 3'd3,
    SAT   = 3'd4
  } state_t;

  localparam int GFRAC_DEF  = 5;
  localparam int GAIN_UNITY = 1 << GFRAC_DEF;

  localparam logic [1:0] SEL_B = 2'd0;
  localparam logic [1:0] SEL_M = 2'd1;
  localparam logic [1:0] SEL_A = 2'd2;

  function automatic int gain_unity(input int gfrac);
    return 1 << gfrac;
  endfunction

endpackage

// File: rtl/ecualizador_mezcla_saturador.sv
// Combinational signed clamp from a wide accumulator to OUT_W bits.
// Also used by the volume stage.
module saturador #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 23
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val
);

  localparam logic signed [IN_W-1:0] MAX_V =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V =
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    if (in_val > MAX_V) begin
      out_val = MAX_V[OUT_W-1:0];
    end else if (in_val < MIN_V) begin
      out_val = MIN_V[OUT_W-1:0];
    end else begin
      out_val = in_val[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ecualizador_mezcla.sv
// Three-band gain-and-sum: one shared multiplier walks low, mid and high
// bands, then the scaled sum is saturated and presented once per strobe.
module ecualizador_mezcla
  import ecualizador_mezcla_pkg::*;
#(
  parameter int N     = 23,
  parameter int G     = 8,
  parameter int GFRAC = GFRAC_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         gen_enable,
  input  logic [N-1:0] out_b,
  input  logic [N-1:0] out_m,
  input  logic [N-1:0] out_a,
  input  logic         gain_we,
  input  logic [1:0]   gain_sel,
  input  logic [G-1:0] gain_data,
  output logic [N-1:0] dato_salida,
  output logic         salida_valid,
  output logic         busy,
  output logic         overrun
);

  localparam int PW = N + G + 1;
  localparam int AW = N + G + 3;
  localparam logic [G-1:0] UNITY = G'(gain_unity(GFRAC));

  state_t               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [N-1:0]  samp_q [3];
  logic signed [N-1:0]  samp_d [3];
  logic [G-1:0]         gpend_q [3];
  logic [G-1:0]         gpend_d [3];
  logic [G-1:0]         gact_q [3];
  logic [G-1:0]         gact_d [3];
  logic [N-1:0]         dato_q, dato_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic signed [N-1:0]  mul_s;
  logic [G-1:0]         mul_g;
  logic signed [PW-1:0] s_ext, g_ext, prod;
  logic signed [AW-1:0] shifted;
  logic signed [N-1:0]  sat_out;

  // Operand mux for the single shared multiplier, steered by the FSM state.
  always_comb begin
    case (state_q)
      MUL_M: begin
        mul_s = samp_q[1];
        mul_g = gact_q[1];
      end
      MUL_A: begin
        mul_s = samp_q[2];
        mul_g = gact_q[2];
      end
      default: begin
        mul_s = samp_q[0];
        mul_g = gact_q[0];
      end
    endcase
    s_ext   = PW'(mul_s);
    g_ext   = PW'({1'b0, mul_g});
    prod    = s_ext * g_ext;
    shifted = acc_q >>> GFRAC;
  end

  saturador #(
    .IN_W  (AW),
    .OUT_W (N)
  ) u_sat (
    .in_val  (shifted),
    .out_val (sat_out)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    samp_d    = samp_q;
    gpend_d   = gpend_q;
    gact_d    = gact_q;
    dato_d    = dato_q;
    valid_d   = 1'b0;
    overrun_d = gen_enable && (state_q != IDLE);

    if (gain_we) begin
      case (gain_sel)
        SEL_B:   gpend_d[0] = gain_data;
        SEL_M:   gpend_d[1] = gain_data;
        SEL_A:   gpend_d[2] = gain_data;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (gen_enable) begin
          samp_d[0] = out_b;
          samp_d[1] = out_m;
          samp_d[2] = out_a;
          // Old pending values: a write landing this cycle waits a sample.
          gact_d    = gpend_q;
          state_d   = MUL_B;
        end
      end
      MUL_B: begin
        acc_d   = AW'(prod);
        state_d = MUL_M;
      end
      MUL_M: begin
        acc_d   = acc_q + AW'(prod);
        state_d = MUL_A;
      end
      MUL_A: begin
        acc_d   = acc_q + AW'(prod);
        state_d = SAT;
      end
      SAT: begin
        dato_d  = sat_out;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      dato_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        samp_q[i]  <= '0;
        gpend_q[i] <= UNITY;
        gact_q[i]  <= UNITY;
      end
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      dato_q    <= dato_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      samp_q    <= samp_d;
      gpend_q   <= gpend_d;
      gact_q    <= gact_d;
    end
  end

  assign dato_salida  = dato_q;
  assign salida_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ecualizador_mezcla.sv
// Scoreboard bench for ecualizador_mezcla: a cycle model predicts busy,
// valid, overrun and the saturated weighted sum for every strobe.
module tb_ecualizador_mezcla;

  logic        clock = 1'b0;
  logic        reset;
  logic        gen_enable;
  logic [22:0] out_b, out_m, out_a;
  logic        gain_we;
  logic [1:0]  gain_sel;
  logic [7:0]  gain_data;
  logic [22:0] dato_salida;
  logic        salida_valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  logic [22:0] exp_q[$];
  logic [7:0]  pend[3];
  logic [7:0]  act[3];
  logic [22:0] dato_exp;
  int          busy_m, vcnt, n_valid, n_ovr;
  logic        ovr_pend;

  always #5 clock = ~clock;

  ecualizador_mezcla dut (
    .clock        (clock),
    .reset        (reset),
    .gen_enable   (gen_enable),
    .out_b        (out_b),
    .out_m        (out_m),
    .out_a        (out_a),
    .gain_we      (gain_we),
    .gain_sel     (gain_sel),
    .gain_data    (gain_data),
    .dato_salida  (dato_salida),
    .salida_valid (salida_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  function automatic logic [22:0] model(input logic signed [22:0] b, m, a,
                                        input logic [7:0] gb, gm, ga);
    longint s;
    s = longint'(b) * longint'(gb) + longint'(m) * longint'(gm)
      + longint'(a) * longint'(ga);
    s = s >>> 5;
    if (s > 64'sd4194303) return 23'h3FFFFF;
    if (s < -64'sd4194304) return 23'h400000;
    return 23'(s);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      pend[i] = 8'd32;
      act[i]  = 8'd32;
    end
    dato_exp = '0;
    busy_m   = 0;
    vcnt     = 0;
    ovr_pend = 1'b0;
  endtask

  // One clock of stimulus, called at posedge+1; checks outputs at the negedge.
  task automatic cycle(input logic stb, input logic signed [22:0] b, m, a,
                       input logic we, input logic [1:0] sel, input logic [7:0] gd);
    logic exp_valid, accept, drop;
    gen_enable = stb; out_b = b; out_m = m; out_a = a;
    gain_we = we; gain_sel = sel; gain_data = gd;
    exp_valid = (vcnt == 1);
    @(negedge clock);
    checks++;
    if (salida_valid !== exp_valid) begin
      errors++;
      $display("FAIL valid: got %b expected %b", salida_valid, exp_valid);
    end
    checks++;
    if (busy !== (busy_m != 0)) begin
      errors++;
      $display("FAIL busy: got %b expected %b", busy, (busy_m != 0));
    end
    checks++;
    if (overrun !== ovr_pend) begin
      errors++;
      $display("FAIL overrun: got %b expected %b", overrun, ovr_pend);
    end
    if (overrun === 1'b1) n_ovr++;
    if (salida_valid === 1'b1) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got unexpected output %h expected none", dato_salida);
      end else begin
        dato_exp = exp_q.pop_front();
        $display("out %h expected %h", dato_salida, dato_exp);
      end
    end
    checks++;
    if (dato_salida !== dato_exp) begin
      errors++;
      $display("FAIL dato_salida: got %h expected %h", dato_salida, dato_exp);
    end
    accept = stb && (busy_m == 0);
    drop   = stb && (busy_m != 0);
    if (vcnt > 0) vcnt--;
    if (accept) begin
      act = pend;
      exp_q.push_back(model(b, m, a, act[0], act[1], act[2]));
      busy_m = 4;
      vcnt   = 5;
    end else if (busy_m > 0) begin
      busy_m--;
    end
    if (we && sel != 2'd3) pend[sel] = gd;
    ovr_pend = drop;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 23'sd0, 23'sd0, 23'sd0, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] gd);
    cycle(1'b0, 23'sd0, 23'sd0, 23'sd0, 1'b1, sel, gd);
  endtask

  task automatic strobe(input logic signed [22:0] b, m, a);
    cycle(1'b1, b, m, a, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic drain();
    idle(8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending outputs expected 0", exp_q.size());
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    gen_enable = 1'b0; gain_we = 1'b0; gain_sel = 2'd0; gain_data = 8'd0;
    out_b = '0; out_m = '0; out_a = '0;
    #1;
    checks++;
    if (dato_salida !== 23'd0 || salida_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got dato=%h valid=%b busy=%b ovr=%b expected all 0",
               dato_salida, salida_valid, busy, overrun);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    idle(3);
  endtask

  task automatic test_unity();
    strobe(23'sd1000, 23'sd2000, -23'sd500);
    drain();
    checks++;
    if (dato_salida !== 23'd2500) begin
      errors++;
      $display("FAIL unity: got %0d expected 2500", $signed(dato_salida));
    end
  endtask

  task automatic test_gain();
    wr(2'd0, 8'd64);
    strobe(23'sd1000, 23'sd0, 23'sd0);
    drain();
    checks++;
    if (dato_salida !== 23'd2000) begin
      errors++;
      $display("FAIL gain_x2: got %0d expected 2000", $signed(dato_salida));
    end
    wr(2'd0, 8'd16);
    strobe(-23'sd1, 23'sd0, 23'sd0);
    drain();
    checks++;
    if (dato_salida !== 23'h7FFFFF) begin
      errors++;
      $display("FAIL floor: got %0d expected -1", $signed(dato_salida));
    end
  endtask

  task automatic test_saturation();
    wr(2'd0, 8'd255); wr(2'd1, 8'd255); wr(2'd2, 8'd255);
    strobe(23'h3FFFFF, 23'h3FFFFF, 23'h3FFFFF);
    drain();
    checks++;
    if (dato_salida !== 23'h3FFFFF) begin
      errors++;
      $display("FAIL sat_pos: got %h expected 3fffff", dato_salida);
    end
    strobe(23'h400000, 23'h400000, 23'h400000);
    drain();
    checks++;
    if (dato_salida !== 23'h400000) begin
      errors++;
      $display("FAIL sat_neg: got %h expected 400000", dato_salida);
    end
  endtask

  task automatic test_gain_timing();
    wr(2'd0, 8'd32); wr(2'd1, 8'd32); wr(2'd2, 8'd32);
    idle(1);
    cycle(1'b1, 23'sd0, 23'sd100, 23'sd0, 1'b1, 2'd1, 8'd0);
    drain();
    checks++;
    if (dato_salida !== 23'd100) begin
      errors++;
      $display("FAIL same_cycle_write: got %0d expected 100", $signed(dato_salida));
    end
    strobe(23'sd0, 23'sd100, 23'sd0);
    drain();
    checks++;
    if (dato_salida !== 23'd0) begin
      errors++;
      $display("FAIL next_sample_gain: got %0d expected 0", $signed(dato_salida));
    end
    wr(2'd3, 8'd0);
    strobe(23'sd100, 23'sd100, 23'sd100);
    drain();
    checks++;
    if (dato_salida !== 23'd200) begin
      errors++;
      $display("FAIL sel3_ignored: got %0d expected 200", $signed(dato_salida));
    end
  endtask

  task automatic test_back_to_back();
    int v0, o0;
    v0 = n_valid;
    o0 = n_ovr;
    strobe(23'sd7, 23'sd0, 23'sd0);
    idle(1);
    strobe(23'sd9, 23'sd0, 23'sd0);
    idle(2);
    strobe(23'sd11, 23'sd0, 23'sd0);
    drain();
    checks++;
    if (n_valid - v0 != 2) begin
      errors++;
      $display("FAIL overrun_valid_count: got %0d expected 2", n_valid - v0);
    end
    checks++;
    if (n_ovr - o0 != 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d expected 1", n_ovr - o0);
    end
  endtask

  task automatic test_reset_midop();
    int v0;
    strobe(23'sd500, 23'sd500, 23'sd500);
    idle(1);
    apply_reset();
    v0 = n_valid;
    idle(8);
    checks++;
    if (n_valid != v0) begin
      errors++;
      $display("FAIL reset_no_valid: got %0d pulses expected 0", n_valid - v0);
    end
    strobe(23'sd10, 23'sd0, 23'sd0);
    drain();
    checks++;
    if (dato_salida !== 23'd10) begin
      errors++;
      $display("FAIL reset_unity: got %0d expected 10", $signed(dato_salida));
    end
  endtask

  initial begin
    n_valid = 0;
    n_ovr   = 0;
    model_reset();
    test_reset();
    test_unity();
    test_gain();
    test_saturation();
    test_gain_timing();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecualizador_mezcla.md
Name: ecualizador_mezcla

Overview:
Gain-and-sum stage directly downstream of the three-band filter bank. It captures the low, mid and high band samples on each sample strobe and applies a per-band user gain. It sums the three weighted bands, saturates the result to the sample width and presents one equalised output sample per strobe. A single shared multiplier is time-multiplexed under an FSM, and gain updates are buffered so they take effect only on sample boundaries.

Parameters:
N, 23, sample width: signed two's complement, same format as the filter bank outputs.
G, 8, gain width: unsigned.
GFRAC, 5, gain fractional bits. Unity gain = 2^GFRAC = 32; range 0 to 7.97.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
gen_enable  in  1  one-cycle sample strobe, same strobe that drives the filter bank
out_b  in  N  low band sample (signed)
out_m  in  N  mid band sample (signed)
out_a  in  N  high band sample (signed)
gain_we  in  1  gain write enable, one cycle
gain_sel  in  2  gain select: 0 = low, 1 = mid, 2 = high, 3 = ignored
gain_data  in  G  gain value (unsigned, Q(G-GFRAC).GFRAC)
dato_salida  out  N  equalised sample (signed)
salida_valid  out  1  one-cycle pulse when dato_salida updates
busy  out  1  high while a sample is in process (state != IDLE)
overrun  out  1  one-cycle pulse when a strobe is dropped

Behaviour:
- Reset (reset=0, async), all values take effect immediately:
  - dato_salida=0, salida_valid=0, busy=0, overrun=0.
  - Accumulator = 0, FSM = IDLE.
  - Pending and active gains all = 32 (unity).
- Gain writes:
  - gain_we=1 with gain_sel 0..2 updates that band's pending register at the clock edge.
  - gain_sel=3 is ignored.
  - Writes are accepted in any FSM state.
- Gain activation:
  - Pending gains are copied to active gains only when a strobe is accepted.
  - A write in the same cycle as an accepted strobe does not affect that sample; it applies to the next one.
- FSM states: IDLE, MUL_B, MUL_M, MUL_A, SAT.
  - IDLE: on gen_enable=1, latch out_b/out_m/out_a and copy pending to active gains, then go to MUL_B. Otherwise stay in IDLE.
  - MUL_B: acc <= sext(b) * zext(gb); go to MUL_M.
  - MUL_M: acc <= acc + m*gm; go to MUL_A.
  - MUL_A: acc <= acc + a*ga; go to SAT.
  - SAT: dato_salida <= sat(acc >>> GFRAC); salida_valid <= 1 for exactly one cycle; go to IDLE.
- Latency: strobe sampled at edge k ⇒ dato_salida/salida_valid visible after edge k+4.
  - Minimum strobe spacing is 5 cycles.
  - A strobe exactly 5 cycles after the previous accepted strobe is accepted.
- Overrun: gen_enable=1 in any non-IDLE state (including SAT) is dropped and not queued.
  - overrun pulses one cycle after the dropped strobe.
  - Inputs and processing of the in-flight sample are unaffected.
- Arithmetic:
  - Product width N+G+1: signed sample times zero-extended gain.
  - Accumulator width N+G+3, so it cannot overflow for 3 terms.
  - Scaling is an arithmetic right shift by GFRAC (truncate toward −inf, no rounding).
- Saturation: clamp to [−2^(N−1), 2^(N−1)−1] = [0x400000, 0x3FFFFF] for N=23.
- Output hold: dato_salida holds its value between valid pulses.
- Reset mid-operation: the in-flight sample is discarded, no valid pulse is produced, and gains return to unity.

Decomposition:
- Shared package/include file holds:
  - FSM state encodings (IDLE..SAT);
  - GAIN_UNITY = 1<<GFRAC;
  - gain_sel codes SEL_B/SEL_M/SEL_A.
- One sub-module, saturador: purely combinational. Accumulator-width signed in, N-bit clamped out, parameterised by input and output widths. It is reused later by the volume stage.

Test Plan:
- Unity pass-through: reset, strobe with b=1000, m=2000, a=−500 → after 5 cycles dato_salida=2500, salida_valid high exactly 1 cycle, busy high for 4 cycles.
- Gain scaling and floor:
  - Write gain 64 on sel 0, then strobe with b=1000, m=a=0 → 2000.
  - Write gain 16 on sel 0, strobe b=−1 → −1 (floor, not 0).
- Saturation:
  - Gains 255 on all bands, b=m=a=0x3FFFFF → 0x3FFFFF.
  - Same gains, b=m=a=0x400000 → 0x400000.
- Gain timing: write gain 0 on sel 1 in the same cycle as the strobe, with m=100, b=a=0 → output 100. The next strobe with the same inputs → output 0. Writing sel 3 changes no gain.
- Overrun: strobes at cycles 0, 2 and 5 → cycle-2 strobe dropped and overrun pulses at cycle 3; cycle-5 strobe accepted; exactly two valid pulses.
- Reset mid-operation: assert reset during MUL_M → outputs 0 immediately, no valid pulse. After release, a strobe with b=10 and unity gains → 10.
